// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
// Opcode encoding, opcode width and the output-stage state type.
// Optional feature macro used by the top: LU_TXN_CNT_EN.
package logic_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_NOTA = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
    localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

    // Output stage holds at most one result.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/logic_unit_core.sv
// Purely combinational opcode decode for the logic unit.
// Produces the WIDTH-bit result and a reserved-opcode error bit.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    // Select the bitwise function; the reserved opcode yields zero and flags an error.
    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOTA: y = ~a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: begin
                y   = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready on both sides,
// one-cycle latency, chaining accumulator and result status flags.
// Optional transaction counter enabled by defining LU_TXN_CNT_EN;
// without it txn_cnt is tied to zero and no counter flops exist.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_use_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_err,
    output logic [WIDTH-1:0] acc_q,
    output logic [CNT_W-1:0] txn_cnt
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready depends only on the output stage (empty, or being
    // drained this cycle), never on in_valid, so a full stage that is drained
    // can take a new operand in the same cycle. out_* stay stable while
    // out_valid=1 and out_ready=0.

    out_state_t       state_q;
    out_state_t       state_d;
    logic             accept;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] core_y;
    logic             core_err;

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = (state_q == ST_EMPTY) | out_ready;
    assign accept    = in_valid & in_ready;

    // Chained ops use the accumulator value from before this cycle's update.
    assign operand_b = in_use_acc ? acc_q : in_b;

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (in_a),
        .b   (operand_b),
        .op  (in_op),
        .y   (core_y),
        .err (core_err)
    );

    // Output stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output stage next state: a new accept refills, a drain without refill empties.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Result and flags are captured together on accept and otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_y    <= '0;
            out_zero <= 1'b0;
            out_ones <= 1'b0;
            out_err  <= 1'b0;
        end else if (accept) begin
            out_y    <= core_y;
            out_zero <= (core_y == '0);
            out_ones <= (core_y == '1);
            out_err  <= core_err;
        end
    end

    // Accumulator follows each accepted result; a clear in the same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (acc_clr) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= core_y;
        end
    end

`ifdef LU_TXN_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of accepted transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign txn_cnt = cnt_q;
`else
    assign txn_cnt = '0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe at WIDTH=4: table vectors,
// hand-written handshake/accumulator/reset sequences and a random run,
// all compared against a truth-table reference model and result queue.
module tb_logic_unit_pipe;

    localparam int W     = 4;
    localparam int CNT_W = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [2:0]       in_op;
    logic             in_use_acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_y;
    logic             out_zero;
    logic             out_ones;
    logic             out_err;
    logic [W-1:0]     acc_q;
    logic [CNT_W-1:0] txn_cnt;

    logic_unit_pipe #(
        .WIDTH (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_use_acc (in_use_acc),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_zero   (out_zero),
        .out_ones   (out_ones),
        .out_err    (out_err),
        .acc_q      (acc_q),
        .txn_cnt    (txn_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W:0] exp_q[$];      // {err, y} of results not yet drained
    logic [W-1:0] m_acc;
    int m_cnt;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] y;
        logic         err;
    } vec_t;
    vec_t tv[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each opcode is a two-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [W:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic [3:0]   tt;
        logic [W-1:0] y;
        logic         err;
        err = 1'b0;
        case (op)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0011;
            3'd3:    tt = 4'b0111;
            3'd4:    tt = 4'b0001;
            3'd5:    tt = 4'b0110;
            3'd6:    tt = 4'b1001;
            default: begin tt = 4'b0000; err = 1'b1; end
        endcase
        for (int i = 0; i < W; i++) y[i] = tt[{a[i], b[i]}];
        return {err, y};
    endfunction

    task automatic check_outputs();
        logic [W:0] e;
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            check("out_y", 32'(out_y), 32'(e[W-1:0]));
            check("out_zero", 32'(out_zero), 32'(e[W-1:0] == '0));
            check("out_ones", 32'(out_ones), 32'(e[W-1:0] == '1));
            check("out_err", 32'(out_err), 32'(e[W]));
        end
        check("acc_q", 32'(acc_q), 32'(m_acc));
`ifdef LU_TXN_CNT_EN
        check("txn_cnt", 32'(txn_cnt), 32'(m_cnt));
`else
        check("txn_cnt", 32'(txn_cnt), 32'd0);
`endif
    endtask

    // Driver: called just after a falling edge; applies one cycle of inputs,
    // advances the model at the rising edge and checks at the next falling edge.
    task automatic drive_cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] op, input logic ua, input logic clr,
                               input logic ordy);
        logic exp_ready, acc, pop;
        logic [W:0] res;
        in_valid   = v;
        in_a       = a;
        in_b       = b;
        in_op      = op;
        in_use_acc = ua;
        acc_clr    = clr;
        out_ready  = ordy;
        #1;
        exp_ready = (exp_q.size() == 0) || ordy;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = v && exp_ready;
        pop = (exp_q.size() != 0) && ordy;
        res = ref_op(op, a, ua ? m_acc : b);
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(res);
        if (clr) m_acc = '0;
        else if (acc) m_acc = res[W-1:0];
        if (acc && m_cnt < CNT_MAX) m_cnt++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_cycle(input logic ordy);
        drive_cycle(1'b0, 4'($urandom), 4'($urandom), 3'($urandom), 1'b0, 1'b0, ordy);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_acc = '0;
        m_cnt = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Table: operand pairs 1010/0101 and 1100/1010 through every opcode.
        tv[0]  = '{4'b1010, 4'b0101, 3'd0, 4'b0000, 1'b0};
        tv[1]  = '{4'b1010, 4'b0101, 3'd1, 4'b1111, 1'b0};
        tv[2]  = '{4'b1010, 4'b0101, 3'd2, 4'b0101, 1'b0};
        tv[3]  = '{4'b1010, 4'b0101, 3'd3, 4'b1111, 1'b0};
        tv[4]  = '{4'b1010, 4'b0101, 3'd4, 4'b0000, 1'b0};
        tv[5]  = '{4'b1010, 4'b0101, 3'd5, 4'b1111, 1'b0};
        tv[6]  = '{4'b1010, 4'b0101, 3'd6, 4'b0000, 1'b0};
        tv[7]  = '{4'b1111, 4'b1111, 3'd7, 4'b0000, 1'b1};
        tv[8]  = '{4'b1100, 4'b1010, 3'd0, 4'b1000, 1'b0};
        tv[9]  = '{4'b1100, 4'b1010, 3'd1, 4'b1110, 1'b0};
        tv[10] = '{4'b1100, 4'b1010, 3'd2, 4'b0011, 1'b0};
        tv[11] = '{4'b1100, 4'b1010, 3'd3, 4'b0111, 1'b0};
        tv[12] = '{4'b1100, 4'b1010, 3'd4, 4'b0001, 1'b0};
        tv[13] = '{4'b1100, 4'b1010, 3'd5, 4'b0110, 1'b0};
        tv[14] = '{4'b1100, 4'b1010, 3'd6, 4'b1001, 1'b0};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_op      = '0;
        in_use_acc = 1'b0;
        acc_clr    = 1'b0;
        out_ready  = 1'b0;
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        check("rst_out_ones", 32'(out_ones), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_acc_q", 32'(acc_q), 32'd0);
        check("rst_txn_cnt", 32'(txn_cnt), 32'd0);
        rst_n = 1'b1;

        // Table vectors back-to-back with the consumer always ready.
        for (int i = 0; i < 15; i++) begin
            drive_cycle(1'b1, tv[i].a, tv[i].b, tv[i].op, 1'b0, 1'b0, 1'b1);
            check($sformatf("tv%0d_y", i), 32'(out_y), 32'(tv[i].y));
            check($sformatf("tv%0d_err", i), 32'(out_err), 32'(tv[i].err));
        end
        idle_cycle(1'b1);

        // Stall: result 0110 held for two cycles while a new input waits.
        drive_cycle(1'b1, 4'b1100, 4'b1010, 3'd5, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 4'b1010, 4'b0101, 3'd1, 1'b0, 1'b0, 1'b0);
            check("stall_y", 32'(out_y), 32'h6);
        end
        drive_cycle(1'b1, 4'b1010, 4'b0101, 3'd1, 1'b0, 1'b0, 1'b1);
        check("release_y", 32'(out_y), 32'hF);
        idle_cycle(1'b1);

        // Accumulator chaining and clear priority.
        drive_cycle(1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b1, 1'b1);
        check("acc_clr_idle", 32'(acc_q), 32'd0);
        drive_cycle(1'b1, 4'b1100, 4'b1010, 3'd5, 1'b0, 1'b0, 1'b1);
        check("acc_xor", 32'(acc_q), 32'h6);
        drive_cycle(1'b1, 4'b1111, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b1);
        check("acc_chain_y", 32'(out_y), 32'h6);
        drive_cycle(1'b1, 4'b1111, 4'b0000, 3'd1, 1'b1, 1'b1, 1'b1);
        check("acc_clr_wins", 32'(acc_q), 32'd0);
        check("acc_clr_old_y", 32'(out_y), 32'hF);

        // Reserved opcode.
        drive_cycle(1'b1, 4'b1010, 4'b0000, 3'd1, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 4'b1111, 4'b1111, 3'd7, 1'b0, 1'b0, 1'b1);
        check("rsvd_y", 32'(out_y), 32'd0);
        check("rsvd_err", 32'(out_err), 32'd1);
        check("rsvd_acc", 32'(acc_q), 32'd0);

        // Asynchronous reset while FULL.
        drive_cycle(1'b1, 4'b1100, 4'b0011, 3'd1, 1'b0, 1'b0, 1'b0);
        check("pre_rst_full", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_acc", 32'(acc_q), 32'd0);
        check("async_rst_cnt", 32'(txn_cnt), 32'd0);
        check("async_rst_y", 32'(out_y), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Three accepts after reset.
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 6)), 1'b0, 1'b0, 1'b1);
`ifdef LU_TXN_CNT_EN
        check("txn_cnt_3", 32'(txn_cnt), 32'd3);
`endif

        // Random traffic: valid, ready, clear and chaining all random.
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                        3'($urandom), 1'($urandom), 1'($urandom_range(0, 9) == 0),
                        1'($urandom_range(0, 2) != 0));
        end
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
